dram_avl_master: RTL and testbench
==================================

DRAM_AVL_MASTER -- requirements
Module: dram_avl_master

Interface
REQ-001 SHALL have parameter DATA_W, default 256, Avalon data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 26, Avalon word address width.
REQ-003 SHALL have parameter BURST_W, default 4, burstcount width (legal bursts 1..8).
REQ-004 SHALL have parameter MAX_PEND, default 32, response buffer depth in beats (power of two, >= 8).
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk_50mhz  in  1  clock; rst_50mhz  in  1  reset.
REQ-006 SHALL have these request ports: req_valid in 1; req_ready out 1; req_write in 1 (1 = write, 0 = read); req_addr in ADDR_W; req_burst in BURST_W.
REQ-007 SHALL have these write-data ports: wdata_valid in 1; wdata_ready out 1; wdata in DATA_W; wdata_be in DATA_W/8.
REQ-008 SHALL have these read-response ports: rsp_valid out 1; rsp_ready in 1; rsp_data out DATA_W.
REQ-009 SHALL have these Avalon-MM master ports: avm_address out ADDR_W; avm_read out 1; avm_write out 1; avm_burstcount out BURST_W; avm_writedata out DATA_W; avm_byteenable out DATA_W/8; avm_waitrequest in 1; avm_readdata in DATA_W; avm_readdatavalid in 1.
REQ-010 SHALL have these status ports: busy out 1 (state != IDLE or reserved != 0); err_rsp out 1 (sticky).

Function
REQ-011 SHALL implement the FSM states IDLE, RD_CMD and WR_BURST.
REQ-012 In IDLE, req_ready SHALL be 1 when req_write = 1, or when reserved + burst <= MAX_PEND.
REQ-013 A req_burst value of 0 SHALL be treated as 1.
REQ-014 When a read is accepted in cycle N, the block SHALL go to RD_CMD and drive avm_read = 1 from registers in cycle N+1, with address and burstcount registered.
REQ-015 avm_read SHALL be held with all Avalon outputs stable until avm_waitrequest = 0, then the block SHALL return to IDLE.
REQ-016 When a write is accepted, the block SHALL go to WR_BURST and load a beat counter with the burst length; address and burstcount SHALL be held for the whole burst.
REQ-017 In WR_BURST, avm_write SHALL equal wdata_valid, avm_writedata/avm_byteenable SHALL equal wdata/wdata_be, and wdata_ready SHALL equal ~avm_waitrequest.
REQ-018 A write beat SHALL transfer when wdata_valid & ~avm_waitrequest; the last beat SHALL return the block to IDLE in the next cycle.
REQ-019 wdata_ready SHALL be 0 outside WR_BURST.
REQ-020 Outside their command states, avm_read and avm_write SHALL be 0.
REQ-021 The reserved counter (width log2(MAX_PEND)+1) SHALL increase by the burst length on read accept and decrease by 1 on each rsp_valid & rsp_ready; on simultaneous events it SHALL apply the net change.
REQ-022 Every avm_readdatavalid beat SHALL be pushed into the response FIFO; the FIFO SHALL never overflow while the credit rule holds.
REQ-023 rsp_valid SHALL assert one cycle after a push into an empty FIFO, and beats SHALL be delivered in arrival order.
REQ-024 An avm_readdatavalid beat arriving when the FIFO is full, or when no beats are pending, SHALL be dropped and SHALL set err_rsp.
REQ-025 A new request SHALL NOT be accepted in the cycle its predecessor completes; the minimum is one IDLE cycle between commands.

Reset
REQ-026 While rst_50mhz = 1, the block SHALL be asynchronously in IDLE with reserved = 0, the FIFO empty, the beat counter 0 and err_rsp = 0.
REQ-027 While rst_50mhz = 1, all outputs SHALL be 0, except that Avalon address/data outputs may be any value while read and write are 0.
REQ-028 Reset mid-burst SHALL abort the burst without completing remaining beats; stale readdatavalid beats arriving after reset SHALL be handled per REQ-024.

Structure
REQ-029 Default widths, MAX_PEND and the FSM state encoding SHALL live in the shared package dram_pkg.
REQ-030 The response buffer SHALL be the sub-module avl_rsp_fifo: synchronous show-ahead FIFO, DATA_W x MAX_PEND, with full/empty/count outputs.

Verification
REQ-031 Single read: read addr 0x100, burst 1, waitrequest = 1 for 3 cycles -> avm_read held 4 cycles with address stable; readdata 0xA5 -> rsp_data 0xA5 one cycle later.
REQ-032 Write burst 4: addr 0x20, data D0..D3, waitrequest toggling -> exactly 4 avm_write transfers in order, burstcount 4 constant, then IDLE.
REQ-033 Credit limit (MAX_PEND = 32): four 8-beat reads with rsp_ready = 0 -> the fifth read request is stalled (req_ready = 0); popping 8 beats -> the fifth is accepted.
REQ-034 Unsolicited readdatavalid with reserved = 0 -> beat dropped, err_rsp = 1 and stays 1.
REQ-035 Reset asserted mid write burst after 2 of 4 beats -> avm_write = 0 immediately, busy = 0, next request accepted normally.
REQ-036 Simultaneous read accept (burst 2) and response pop -> reserved changes by +1.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM Avalon-MM master slice.
// Holds the default interface widths, the response buffer depth and the
// encoding of the command FSM so that every file agrees on them.
package dram_pkg;

    localparam int DEF_DATA_W   = 256;
    localparam int DEF_ADDR_W   = 26;
    localparam int DEF_BURST_W  = 4;
    localparam int DEF_MAX_PEND = 32;

    // Command FSM: idle/arbitration, read command issue, write burst.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_CMD   = 2'd1,
        WR_BURST = 2'd2
    } avl_state_t;

endpackage

// File: rtl/avl_rsp_fifo.sv
// Read-response buffer: synchronous show-ahead FIFO.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push, din       write side; pushes are ignored while full
//   pop             read side; pops are ignored while empty
//   dout            head entry (driven to 0 while empty)
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module avl_rsp_fifo
    import dram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_MAX_PEND
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         din,
    input  logic                      pop,
    output logic [DATA_W-1:0]         dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Show-ahead: the head entry is visible as soon as it is stored. Forced
    // to zero while empty so the read data port is quiet during reset.
    assign dout = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array needs no reset; only entries behind the pointers are read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dram_avl_master.sv
// Avalon-MM burst master bridging a simple request/write-data/response
// interface onto a DRAM controller port.
// Ports:
//   clk_50mhz, rst_50mhz         clock, asynchronous active-high reset
//   req_*                        command request (valid/ready, write, addr, burst)
//   wdata_*                      write beat stream (valid/ready, data, byte enables)
//   rsp_*                        read response stream (valid/ready, data)
//   avm_*                        Avalon-MM master port
//   busy                         command in flight or read beats still owed
//   err_rsp                      sticky: a readdatavalid beat had to be dropped
module dram_avl_master
    import dram_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BURST_W  = DEF_BURST_W,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                  clk_50mhz,
    input  logic                  rst_50mhz,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [BURST_W-1:0]    req_burst,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wdata_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [BURST_W-1:0]    avm_burstcount,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  busy,
    output logic                  err_rsp
);

    localparam int RSV_W = $clog2(MAX_PEND) + 1;
    localparam int SUM_W = RSV_W + BURST_W;

    avl_state_t          state;
    avl_state_t          state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [BURST_W-1:0]  burst_q;
    logic [BURST_W-1:0]  beat_cnt;
    logic [BURST_W-1:0]  burst_len;
    logic [RSV_W-1:0]    reserved;
    logic [RSV_W-1:0]    rsv_next;
    logic [RSV_W-1:0]    fifo_count;
    logic [SUM_W-1:0]    credit_sum;
    logic                credit_ok;
    logic                req_accept;
    logic                rd_accept;
    logic                wr_accept;
    logic                wr_xfer;
    logic                rsp_pop;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    logic                beat_owed;

    // A zero burstcount means a single beat.
    assign burst_len  = (req_burst == '0) ? BURST_W'(1) : req_burst;

    // Read credit: every beat reserved must fit in the response buffer, so
    // the FIFO cannot overflow while responses are held back.
    assign credit_sum = SUM_W'(reserved) + SUM_W'(burst_len);
    assign credit_ok  = (credit_sum <= SUM_W'(MAX_PEND));

    assign req_accept = req_valid & req_ready;
    assign rd_accept  = req_accept & ~req_write;
    assign wr_accept  = req_accept & req_write;
    assign wr_xfer    = (state == WR_BURST) & wdata_valid & ~avm_waitrequest;

    assign rsp_valid  = ~fifo_empty;
    assign rsp_pop    = rsp_valid & rsp_ready;

    // Beats still owed by the controller = reserved minus those already
    // buffered. A beat with nothing owed (e.g. stale after reset) is dropped.
    assign beat_owed  = (reserved != fifo_count);
    assign fifo_push  = avm_readdatavalid & ~fifo_full & beat_owed;

    assign avm_address    = addr_q;
    assign avm_burstcount = burst_q;
    assign busy           = (state != IDLE) | (reserved != '0);

    // State register.
    always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
        if (rst_50mhz) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state and command-port decode. Requests are only taken from IDLE,
    // which guarantees one idle cycle between back-to-back commands. The
    // write data path is a straight pass-through gated by the burst state.
    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        wdata_ready    = 1'b0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_writedata  = '0;
        avm_byteenable = '0;
        case (state)
            IDLE: begin
                req_ready = ~rst_50mhz & (req_write | credit_ok);
                if (req_valid & req_ready)
                    state_next = req_write ? WR_BURST : RD_CMD;
            end
            RD_CMD: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) state_next = IDLE;
            end
            WR_BURST: begin
                avm_write      = wdata_valid;
                avm_writedata  = wdata;
                avm_byteenable = wdata_be;
                wdata_ready    = ~avm_waitrequest;
                if (wr_xfer && beat_cnt <= BURST_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Net credit change: a read accept and a response pop in the same cycle
    // combine into a single update.
    always_comb begin
        rsv_next = reserved;
        if (rd_accept) rsv_next = rsv_next + RSV_W'(burst_len);
        if (rsp_pop)   rsv_next = rsv_next - RSV_W'(1);
    end

    // Command registers, write beat counter, credit counter and the sticky
    // dropped-beat flag. Reset aborts any burst in progress outright.
    always_ff @(posedge clk_50mhz or posedge rst_50mhz) begin
        if (rst_50mhz) begin
            addr_q   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            reserved <= '0;
            err_rsp  <= 1'b0;
        end else begin
            if (req_accept) begin
                addr_q  <= req_addr;
                burst_q <= burst_len;
            end
            if (wr_accept)    beat_cnt <= burst_len;
            else if (wr_xfer) beat_cnt <= beat_cnt - BURST_W'(1);
            reserved <= rsv_next;
            if (avm_readdatavalid && !fifo_push) err_rsp <= 1'b1;
        end
    end

    avl_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_PEND)
    ) u_rsp_fifo (
        .clk   (clk_50mhz),
        .rst   (rst_50mhz),
        .push  (fifo_push),
        .din   (avm_readdata),
        .pop   (rsp_pop),
        .dout  (rsp_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_dram_avl_master.sv
// Self-checking bench for dram_avl_master (DATA_W = 32, MAX_PEND = 32).
// A cycle-by-cycle vector table covers a single read and a 4-beat write;
// hand-written sequences cover credit stall, net credit update, unsolicited
// beats and reset in the middle of a write burst.
module tb_dram_avl_master;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int BW = 4;
    localparam int MP = 32;

    logic            clk_50mhz = 1'b0;
    logic            rst_50mhz = 1'b1;
    logic            req_valid, req_ready, req_write;
    logic [AW-1:0]   req_addr;
    logic [BW-1:0]   req_burst;
    logic            wdata_valid, wdata_ready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wdata_be;
    logic            rsp_valid, rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   avm_address;
    logic            avm_read, avm_write;
    logic [BW-1:0]   avm_burstcount;
    logic [DW-1:0]   avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic            avm_waitrequest;
    logic [DW-1:0]   avm_readdata;
    logic            avm_readdatavalid;
    logic            busy, err_rsp;

    int checks = 0;
    int errors = 0;

    always #5 clk_50mhz = ~clk_50mhz;

    dram_avl_master #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .MAX_PEND(MP)
    ) dut (
        .clk_50mhz(clk_50mhz), .rst_50mhz(rst_50mhz),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_burst(req_burst),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata(wdata), .wdata_be(wdata_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .err_rsp(err_rsp)
    );

    // ectl = {req_ready, wdata_ready, avm_read, avm_write, rsp_valid, busy}
    typedef struct {
        logic        rv, rw;
        logic [15:0] addr;
        logic [3:0]  burst;
        logic        wv;
        logic [31:0] wd;
        logic        wreq, rdv;
        logic [31:0] rd;
        logic        rr;
        logic [5:0]  ectl;
        logic [15:0] eaddr;
        logic [3:0]  ebc;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    localparam int NVEC = 18;
    vec_t        vecs [NVEC];
    logic [31:0] wr_log [$];

    function automatic vec_t mk(input logic rv, rw, input logic [15:0] addr,
                                input logic [3:0] burst, input logic wv,
                                input logic [31:0] wd, input logic wreq, rdv,
                                input logic [31:0] rd, input logic rr,
                                input logic [5:0] ectl, input logic [15:0] eaddr,
                                input logic [3:0] ebc, input logic [31:0] ewd,
                                input logic [31:0] erd);
        vec_t v;
        v.rv = rv; v.rw = rw; v.addr = addr; v.burst = burst; v.wv = wv;
        v.wd = wd; v.wreq = wreq; v.rdv = rdv; v.rd = rd; v.rr = rr;
        v.ectl = ectl; v.eaddr = eaddr; v.ebc = ebc; v.ewd = ewd; v.erd = erd;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        req_valid         = v.rv;
        req_write         = v.rw;
        req_addr          = AW'(v.addr);
        req_burst         = v.burst;
        wdata_valid       = v.wv;
        wdata             = v.wd;
        wdata_be          = 4'hF;
        avm_waitrequest   = v.wreq;
        avm_readdatavalid = v.rdv;
        avm_readdata      = v.rd;
        rsp_ready         = v.rr;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        applyStimulus(mk(0,0,0,0, 0,0, 0, 0,0, 0, 0,0,0,0,0));
    endtask

    task automatic doReset();
        @(negedge clk_50mhz);
        rst_50mhz = 1'b1;
        clearInputs();
        @(negedge clk_50mhz);
        rst_50mhz = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Single read with 3 waitrequest cycles, response A5; then a 4-beat
        // write at 0x20 with waitrequest toggling and a valid gap.
        vecs[0]  = mk(1,0,'h100,1, 0,0,     1, 0,0,    0, 6'b100000, 0,0,0,0);
        vecs[1]  = mk(0,0,'h100,1, 0,0,     1, 0,0,    0, 6'b001001, 'h100,1,0,0);
        vecs[2]  = mk(0,0,'h100,1, 0,0,     1, 0,0,    0, 6'b001001, 'h100,1,0,0);
        vecs[3]  = mk(0,0,'h100,1, 0,0,     1, 0,0,    0, 6'b001001, 'h100,1,0,0);
        vecs[4]  = mk(0,0,'h100,1, 0,0,     0, 0,0,    0, 6'b001001, 'h100,1,0,0);
        vecs[5]  = mk(0,0,0,1,     0,0,     0, 1,'hA5, 1, 6'b100001, 0,0,0,0);
        vecs[6]  = mk(0,0,0,1,     0,0,     0, 0,0,    1, 6'b100011, 0,0,0,'hA5);
        vecs[7]  = mk(0,0,0,1,     0,0,     0, 0,0,    1, 6'b100000, 0,0,0,0);
        vecs[8]  = mk(1,1,'h20,4,  0,0,     0, 0,0,    0, 6'b100000, 0,0,0,0);
        vecs[9]  = mk(0,0,'h20,4,  1,'hD0,  1, 0,0,    0, 6'b000101, 'h20,4,'hD0,0);
        vecs[10] = mk(0,0,'h20,4,  1,'hD0,  0, 0,0,    0, 6'b010101, 'h20,4,'hD0,0);
        vecs[11] = mk(0,0,'h20,4,  1,'hD1,  1, 0,0,    0, 6'b000101, 'h20,4,'hD1,0);
        vecs[12] = mk(0,0,'h20,4,  1,'hD1,  0, 0,0,    0, 6'b010101, 'h20,4,'hD1,0);
        vecs[13] = mk(0,0,'h20,4,  0,'hEE,  0, 0,0,    0, 6'b010001, 0,0,0,0);
        vecs[14] = mk(0,0,'h20,4,  1,'hD2,  0, 0,0,    0, 6'b010101, 'h20,4,'hD2,0);
        vecs[15] = mk(0,0,'h20,4,  1,'hD3,  1, 0,0,    0, 6'b000101, 'h20,4,'hD3,0);
        vecs[16] = mk(0,0,'h20,4,  1,'hD3,  0, 0,0,    0, 6'b010101, 'h20,4,'hD3,0);
        vecs[17] = mk(0,0,0,1,     0,0,     0, 0,0,    0, 6'b100000, 0,0,0,0);

        // Reset state, with a request pending to show req_ready stays low.
        clearInputs();
        @(negedge clk_50mhz);
        req_valid = 1'b1;
        #1;
        checkOutput("reset_outputs",
                    64'({req_ready, wdata_ready, rsp_valid, avm_read, avm_write, busy, err_rsp}), 64'd0);
        checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk_50mhz);
        rst_50mhz = 1'b0;
        req_valid = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk_50mhz);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_ctl", i),
                        64'({req_ready, wdata_ready, avm_read, avm_write, rsp_valid, busy}),
                        64'(vecs[i].ectl));
            if (vecs[i].ectl[3])
                checkOutput($sformatf("vec%0d_rdcmd", i),
                            64'({avm_address[15:0], avm_burstcount}),
                            64'({vecs[i].eaddr, vecs[i].ebc}));
            if (vecs[i].ectl[2])
                checkOutput($sformatf("vec%0d_wrcmd", i),
                            64'({avm_address[15:0], avm_burstcount, avm_byteenable, avm_writedata}),
                            64'({vecs[i].eaddr, vecs[i].ebc, 4'hF, vecs[i].ewd}));
            if (vecs[i].ectl[1])
                checkOutput($sformatf("vec%0d_rsp", i), 64'(rsp_data), 64'(vecs[i].erd));
            if (avm_write && !avm_waitrequest) wr_log.push_back(avm_writedata);
        end
        checkOutput("wr_xfer_count", 64'(wr_log.size()), 64'd4);
        for (int k = 0; k < wr_log.size() && k < 4; k++)
            checkOutput($sformatf("wr_xfer%0d", k), 64'(wr_log[k]), 64'('hD0 + k));

        // Credit limit: four 8-beat reads fill all 32 credits.
        for (int r = 0; r < 4; r++) begin
            @(negedge clk_50mhz);
            clearInputs();
            req_valid = 1'b1; req_addr = AW'(r * 8); req_burst = 4'd8;
            #1;
            checkOutput($sformatf("credit_acc%0d", r), 64'(req_ready), 64'd1);
            @(negedge clk_50mhz);
            req_valid = 1'b0;
            #1;
            checkOutput($sformatf("credit_issue%0d", r),
                        64'({avm_read, avm_burstcount}), 64'({1'b1, 4'd8}));
        end
        @(negedge clk_50mhz);
        req_valid = 1'b1; req_addr = AW'('h300); req_burst = 4'd8;
        #1;
        checkOutput("credit_stall", 64'(req_ready), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_50mhz);
            avm_readdatavalid = 1'b1; avm_readdata = 32'h1000 + i;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_50mhz);
            avm_readdatavalid = 1'b0; rsp_ready = 1'b1;
            #1;
            checkOutput($sformatf("credit_hold%0d", k), 64'(req_ready), 64'd0);
            checkOutput($sformatf("credit_pop%0d", k),
                        64'({rsp_valid, rsp_data}), 64'({1'b1, 32'h1000 + k}));
        end
        @(negedge clk_50mhz);
        rsp_ready = 1'b0;
        #1;
        checkOutput("credit_release", 64'(req_ready), 64'd1);
        @(negedge clk_50mhz);
        req_valid = 1'b0;
        #1;
        checkOutput("credit_fifth_issued",
                    64'({avm_read, avm_address[15:0]}), 64'({1'b1, 16'h300}));

        // Simultaneous read accept (burst 2) and response pop.
        doReset();
        @(negedge clk_50mhz);
        req_valid = 1'b1; req_burst = 4'd1; req_addr = AW'('h40);
        @(negedge clk_50mhz);
        req_valid = 1'b0;
        @(negedge clk_50mhz);
        avm_readdatavalid = 1'b1; avm_readdata = 32'h55;
        @(negedge clk_50mhz);
        avm_readdatavalid = 1'b0;
        req_valid = 1'b1; req_burst = 4'd2; rsp_ready = 1'b1;
        #1;
        checkOutput("sim_setup", 64'({req_ready, rsp_valid, rsp_data}), 64'({2'b11, 32'h55}));
        @(negedge clk_50mhz);
        req_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk_50mhz);
        avm_readdatavalid = 1'b1; avm_readdata = 32'h61;
        @(negedge clk_50mhz);
        avm_readdata = 32'h62;
        @(negedge clk_50mhz);
        avm_readdatavalid = 1'b0; rsp_ready = 1'b1;
        #1;
        checkOutput("sim_beat0", 64'({busy, rsp_valid, rsp_data}), 64'({2'b11, 32'h61}));
        @(negedge clk_50mhz);
        #1;
        checkOutput("sim_beat1", 64'({busy, rsp_valid, rsp_data}), 64'({2'b11, 32'h62}));
        @(negedge clk_50mhz);
        rsp_ready = 1'b0;
        #1;
        checkOutput("sim_net", 64'({busy, rsp_valid, err_rsp}), 64'd0);

        // Unsolicited beat with nothing reserved.
        @(negedge clk_50mhz);
        avm_readdatavalid = 1'b1; avm_readdata = 32'h77;
        @(negedge clk_50mhz);
        avm_readdatavalid = 1'b0;
        #1;
        checkOutput("unsol_drop", 64'({rsp_valid, err_rsp}), 64'({1'b0, 1'b1}));
        repeat (3) @(negedge clk_50mhz);
        #1;
        checkOutput("unsol_sticky", 64'({err_rsp, busy}), 64'({1'b1, 1'b0}));

        // Reset in the middle of a 4-beat write after two beats.
        @(negedge clk_50mhz);
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'('h40); req_burst = 4'd4;
        @(negedge clk_50mhz);
        req_valid = 1'b0; req_write = 1'b0;
        wdata_valid = 1'b1; wdata = 32'hB0; avm_waitrequest = 1'b0;
        @(negedge clk_50mhz);
        wdata = 32'hB1;
        @(negedge clk_50mhz);
        wdata = 32'hB2;
        #1;
        checkOutput("midrst_before", 64'({avm_write, busy}), 64'({1'b1, 1'b1}));
        rst_50mhz = 1'b1;
        #1;
        checkOutput("midrst_during",
                    64'({avm_write, busy, wdata_ready, req_ready, err_rsp, rsp_valid}), 64'd0);
        @(negedge clk_50mhz);
        wdata_valid = 1'b0;
        @(negedge clk_50mhz);
        rst_50mhz = 1'b0;
        @(negedge clk_50mhz);
        req_valid = 1'b1; req_addr = AW'('h80); req_burst = 4'd1;
        #1;
        checkOutput("midrst_next_ready", 64'({req_ready, avm_write}), 64'({1'b1, 1'b0}));
        @(negedge clk_50mhz);
        req_valid = 1'b0;
        #1;
        checkOutput("midrst_next_read",
                    64'({avm_read, avm_write, avm_address[15:0]}), 64'({2'b10, 16'h80}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
